// File: rtl/rx_232_capture.sv
// rx_232_capture
//   Receive datapath behind the RS-232 RX control FSM. Shifts serial bits in
//   while S is high. On the rising edge of EOR it captures {ferr, byte}.
//   Captures are buffered in a small first-word-fall-through FIFO.
//
// Ports
//   CLK      baud-rate clock (rising edge)
//   RST      asynchronous reset, active low
//   Rx       serial line
//   S        shift enable from the FSM (9 pulses per frame)
//   EOR      end-of-reception from the FSM (high idle/done)
//   RD       pop request, ignored when empty
//   CLR_OVR  synchronous clear of the overrun flag
//   DATA     head-of-FIFO byte
//   FERR     frame-error flag of the head entry
//   VALID    FIFO not empty
//   FULL     FIFO holds DEPTH entries
//   COUNT    number of stored entries
//   OVR      sticky overrun flag
module rx_232_capture #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          Rx,
   input  logic          S,
   input  logic          EOR,
   input  logic          RD,
   input  logic          CLR_OVR,
   output logic [7:0]    DATA,
   output logic          FERR,
   output logic          VALID,
   output logic          FULL,
   output logic [AW:0]   COUNT,
   output logic          OVR
);

   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

   logic [8:0]    sh_q, sh_d;
   logic [3:0]    bc_q, bc_d;
   logic          eor_q;
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovr_q, ovr_d;
   logic [8:0]    mem_q [DEPTH];

   logic cap, pop, push, drop, full, ferr;

   always_comb begin
      cap  = EOR & ~eor_q;
      full = (cnt_q == CNT_MAX);
      pop  = RD & (cnt_q != '0);
      push = cap & (~full | pop);
      drop = cap & full & ~pop;
      // Stop bit sits in sh[8] once all nine shifts are in. A wrong shift
      // count also marks the frame bad, which covers stale bits in sh.
      ferr = ~sh_q[8] | (bc_q != 4'd9);

      sh_d = S ? {Rx, sh_q[8:1]} : sh_q;

      bc_d = bc_q;
      if (cap)                      bc_d = S ? 4'd1 : 4'd0;
      else if (S && bc_q != 4'hF)   bc_d = bc_q + 4'd1;

      wp_d = push ? wp_q + 1'b1 : wp_q;
      rp_d = pop  ? rp_q + 1'b1 : rp_q;

      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      // A drop takes priority over a coincident clear.
      ovr_d = drop | (ovr_q & ~CLR_OVR);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sh_q  <= '0;
         bc_q  <= '0;
         eor_q <= 1'b1;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sh_q  <= sh_d;
         bc_q  <= bc_d;
         eor_q <= EOR;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
         if (push) mem_q[wp_q] <= {ferr, sh_q[7:0]};
      end
   end

   assign DATA  = mem_q[rp_q][7:0];
   assign FERR  = mem_q[rp_q][8];
   assign VALID = (cnt_q != '0);
   assign FULL  = full;
   assign COUNT = cnt_q;
   assign OVR   = ovr_q;

endmodule

// File: tb/tb_rx_232_capture.sv
module tb_rx_232_capture;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       Rx = 1'b1, S = 1'b0, EOR = 1'b1, RD = 1'b0, CLR_OVR = 1'b0;
   logic [7:0] DATA;
   logic       FERR, VALID, FULL, OVR;
   logic [2:0] COUNT;

   int errors = 0;
   int checks = 0;

   logic [8:0] q[$];     // scoreboard of expected {ferr, data}
   logic [8:0] m_sh;     // bench model of the shift register
   logic       exp_ovr;

   rx_232_capture #(.DEPTH(4), .AW(2)) dut (
      .CLK(CLK), .RST(RST), .Rx(Rx), .S(S), .EOR(EOR), .RD(RD),
      .CLR_OVR(CLR_OVR), .DATA(DATA), .FERR(FERR), .VALID(VALID),
      .FULL(FULL), .COUNT(COUNT), .OVR(OVR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Emulates the FSM: start bit, nbits shift cycles, then EOR rises.
   // Returns just after the push edge (sampled at the following negedge).
   task automatic send(input logic [7:0] d, input logic stop, input int nbits,
                       input logic rd_on_push);
      logic [8:0] fr;
      logic       f;
      logic       can_pop;
      fr = {stop, d};
      @(negedge CLK); EOR = 1'b0; Rx = 1'b0; S = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge CLK); S = 1'b1; Rx = fr[i];
         m_sh = {fr[i], m_sh[8:1]};
      end
      @(negedge CLK); S = 1'b0; Rx = 1'b1; EOR = 1'b1; RD = rd_on_push;
      f = ~m_sh[8] | (nbits != 9);
      can_pop = rd_on_push && (q.size() > 0);
      if (can_pop) begin
         chk("head_before_pop", {23'd0, FERR, DATA}, {23'd0, q[0]});
         void'(q.pop_front());
      end
      if (q.size() < 4) q.push_back({f, m_sh[7:0]});
      else exp_ovr = 1'b1;
      @(negedge CLK); RD = 1'b0;
   endtask

   task automatic pop_chk(input string tag);
      chk({tag, "_valid"}, VALID, 1);
      chk({tag, "_data"}, {23'd0, FERR, DATA}, {23'd0, q[0]});
      RD = 1'b1;
      @(negedge CLK); RD = 1'b0;
      void'(q.pop_front());
      chk({tag, "_count"}, COUNT, q.size());
   endtask

   initial begin
      m_sh = '0; exp_ovr = 1'b0;
      // reset state
      #12;
      chk("rst_data", DATA, 0);   chk("rst_ferr", FERR, 0);
      chk("rst_valid", VALID, 0); chk("rst_full", FULL, 0);
      chk("rst_count", COUNT, 0); chk("rst_ovr", OVR, 0);
      @(negedge CLK); RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("idle_valid", VALID, 0);

      // good frame 0xA5
      send(8'hA5, 1'b1, 9, 1'b0);
      chk("a5_count", COUNT, 1);
      chk("a5_ferr", FERR, 0);
      pop_chk("a5");
      chk("a5_valid_after", VALID, 0);

      // bad stop bit
      send(8'h3C, 1'b0, 9, 1'b0);
      chk("3c_ferr", FERR, 1);
      pop_chk("3c");

      // overrun
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 9, 1'b0);
      chk("full_flag", FULL, 1);
      chk("full_count", COUNT, 4);
      chk("full_ovr0", OVR, 0);
      send(8'h05, 1'b1, 9, 1'b0);
      chk("ovr_set", OVR, exp_ovr);
      chk("ovr_count", COUNT, 4);
      for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovr_pop%0d", i));
      chk("ovr_held", OVR, 1);
      CLR_OVR = 1'b1; @(negedge CLK); CLR_OVR = 1'b0; exp_ovr = 1'b0;
      chk("ovr_clr", OVR, 0);

      // full with simultaneous pop; exercises wrap
      for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 9, 1'b0);
      send(8'h77, 1'b1, 9, 1'b1);
      chk("pp_ovr", OVR, 0);
      chk("pp_count", COUNT, 4);
      chk("pp_head", DATA, 8'h11);
      for (int i = 0; i < 4; i++) pop_chk($sformatf("pp_pop%0d", i));
      chk("pp_last_empty", VALID, 0);

      // reset mid-frame
      @(negedge CLK); EOR = 1'b0; Rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK); S = 1'b1; Rx = i[0];
      end
      @(negedge CLK); RST = 1'b0; S = 1'b0; Rx = 1'b1;
      #1;
      chk("mrst_data", DATA, 0);   chk("mrst_ferr", FERR, 0);
      chk("mrst_valid", VALID, 0); chk("mrst_full", FULL, 0);
      chk("mrst_count", COUNT, 0); chk("mrst_ovr", OVR, 0);
      m_sh = '0;
      @(negedge CLK); EOR = 1'b1;
      @(negedge CLK); RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("mrst_no_spur", VALID, 0);
      send(8'h5A, 1'b1, 9, 1'b0);
      chk("5a_count", COUNT, 1);
      chk("5a_ferr", FERR, 0);
      pop_chk("5a");

      // RD while empty, then short frame
      RD = 1'b1;
      repeat (3) @(negedge CLK);
      RD = 1'b0;
      chk("empty_rd_count", COUNT, 0);
      chk("empty_rd_valid", VALID, 0);
      send(8'h0F, 1'b1, 5, 1'b0);
      chk("short_count", COUNT, 1);
      chk("short_ferr", FERR, 1);
      pop_chk("short");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rx_232_capture.md
# rx_232_capture

Receive datapath for the RS-232 receiver, directly downstream of the receive control FSM. Consumes the FSM's shift-enable (S) and end-of-reception (EOR) strobes together with the serial line. It assembles each frame into a byte, checks the stop bit and bit count, and buffers results in a small first-word-fall-through FIFO read by the host logic. It runs on the same baud-rate clock as the FSM.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 2, FIFO address width; must equal log2(DEPTH).
- CLK  input  1  baud-rate clock shared with the RX FSM; all state changes on its rising edge.
- RST  input  1  asynchronous, active-low reset (0 = reset).
- Rx  input  1  serial line, same signal the FSM samples.
- S  input  1  shift enable from the FSM; high for exactly 9 cycles per frame (8 data bits, then stop).
- EOR  input  1  end-of-reception from the FSM; high while idle/done, low during shifting.
- RD  input  1  pop request; honoured only when VALID=1.
- CLR_OVR  input  1  synchronous clear of OVR.
- DATA  output  8  head-of-FIFO byte; valid when VALID=1.
- FERR  output  1  frame-error flag stored with the head entry.
- VALID  output  1  FIFO not empty.
- FULL  output  1  FIFO holds DEPTH entries.
- COUNT  output  AW+1  number of stored entries, 0..DEPTH.
- OVR  output  1  sticky overrun flag.

## Operation
- Shift register sh[8:0]: on each edge with S=1, sh <= {Rx, sh[8:1]}. The value is LSB first, so after 9 shifts sh[7:0] is the data byte and sh[8] is the stop bit.
- Bit counter bc[3:0]: increments on each S=1 edge and saturates at 15. It clears to 0 on the same edge as a capture, unless S=1 on that edge, in which case it loads 1.
- EOR edge detector: eor_d <= EOR every cycle; reset value 1, so no capture follows reset. Capture strobe cap = EOR & ~eor_d.
- Capture on an edge with cap=1:
  - entry = {ferr, sh[7:0]}.
  - ferr = (sh[8]==0) | (bc != 9).
  - The entry is pushed into the FIFO.
- FIFO:
  - Circular buffer of DEPTH entries with write pointer, read pointer and COUNT.
  - Both pointers wrap modulo DEPTH.
  - DATA and FERR are driven from the entry at the read pointer (first-word fall-through).
- Push/pop rules, evaluated on the same edge:
  - pop = RD & VALID.
  - push = cap & (~FULL | pop).
  - push only: COUNT+1. pop only: COUNT-1. Both: COUNT unchanged and both pointers advance.
  - RD with VALID=0 is ignored; pointers and COUNT are unchanged.
  - cap with FULL=1 and no pop: the entry is dropped, OVR is set, and stored data is untouched.
- OVR: set on a dropped capture and held until CLR_OVR=1. If a drop and CLR_OVR coincide, OVR stays 1 (set wins).
- sh is not cleared by capture. Stale bits are harmless because bc flags any short frame.

## Timing
- Reset (RST=0, asynchronous):
  - Outputs: DATA=0, FERR=0, VALID=0, FULL=0, COUNT=0, OVR=0.
  - Internal state: sh=0, bc=0, eor_d=1, pointers=0, FIFO contents=0.
- Reset mid-frame discards the partial frame. After RST releases, the first capture happens only after a new 1->0->1 sequence on EOR.
- Latency:
  - EOR rises after edge k, the edge on which the FSM leaves its last shift state.
  - cap is high during cycle k..k+1, and the push happens at edge k+1.
  - VALID/DATA update immediately after edge k+1, one cycle after EOR rises.
- Pop: DATA shows the next entry, or VALID falls, immediately after the RD edge.
- No combinational path from inputs to outputs; all outputs come from registers or register-addressed storage.
- Back-to-back frames: at least 11 cycles apart per FSM behaviour. Single-cycle cap pulses are never missed.

## Test plan
- Frame 0xA5 with stop=1: Rx sequence 1, 0 (start), 1,0,1,0,0,1,0,1, 1 (stop) -> one cycle after EOR rises, VALID=1, DATA=0xA5, FERR=0, COUNT=1. RD=1 for one cycle -> VALID=0, COUNT=0.
- Frame 0x3C with stop bit 0 -> DATA=0x3C, FERR=1.
- Five frames 0x01..0x05 with no RD (DEPTH=4):
  - After four frames: FULL=1, COUNT=4.
  - Fifth frame: OVR=1, COUNT stays 4.
  - Four pops return 0x01, 0x02, 0x03, 0x04 in order.
  - CLR_OVR=1 -> OVR=0.
- FIFO full, with RD=1 on the push edge of frame 0x77:
  - OVR stays 0, COUNT stays 4, and the head advances.
  - 0x77 is the last entry read back, which exercises pointer wrap.
- RST pulled low after 4 of 9 S pulses, then released, then a full frame 0x5A sent:
  - All outputs are 0 during reset.
  - No spurious entry appears after release.
  - The following frame gives DATA=0x5A, FERR=0, COUNT=1.
- RD=1 held while empty, and S pulsed only 5 times before EOR rises:
  - No pointer movement while empty.
  - The short frame stores FERR=1.
